parking_gate_arbiter: RTL

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_pkg.sv | 23 ++
 rtl/gate_timer.sv | 29 ++
 rtl/parking_gate_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter.
package parking_pkg;

  localparam int COUNT_W          = 3;
  localparam int DEF_CAPACITY     = 7;
  localparam int DEF_OPEN_TIMEOUT = 50;
  localparam int DEF_CLOSE_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OPEN_ENTRY = 2'd1,
    ST_OPEN_EXIT  = 2'd2,
    ST_CLOSING    = 2'd3
  } gate_state_e;

  // One timer serves both delays, so it is sized for the longer of the two.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the open timeout and the close delay.
// done is the terminal-count compare (counter at zero).
module gate_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_run,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter: shares one barrier between entry and exit traffic,
// tracks occupancy and rejects requests the lot cannot serve.
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_IDLE       | gate down, evaluating pending requests
// ST_OPEN_ENTRY | gate up for an entering car, open timeout running
// ST_OPEN_EXIT  | gate up for a leaving car, open timeout running
// ST_CLOSING    | gate coming down for the close delay; requests queue
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic               car_passed,
  output logic               gate_open,
  output logic               grant_entry,
  output logic               grant_exit,
  output logic               deny,
  output logic               full,
  output logic [COUNT_W-1:0] led_counter
);

  localparam int                 TMR_W      = timer_width(OPEN_TIMEOUT, CLOSE_CYCLES);
  localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0]   OPEN_LOAD  = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   CLOSE_LOAD = TMR_W'(CLOSE_CYCLES - 1);

  gate_state_e        r_state;
  gate_state_e        w_next_state;

  logic               r_entry_pend;
  logic               r_exit_pend;
  logic               r_last_exit;
  logic [COUNT_W-1:0] r_count;
  logic               r_deny;
  logic               r_gate_open;
  logic               r_grant_entry;
  logic               r_grant_exit;

  logic               w_entry_pend;
  logic               w_exit_pend;
  logic               w_entry_ok;
  logic               w_exit_ok;
  logic               w_deny_entry;
  logic               w_deny_exit;
  logic               w_want_entry;
  logic               w_want_exit;

  logic               w_clr_entry;
  logic               w_clr_exit;
  logic               w_deny;
  logic               w_grant_entry;
  logic               w_grant_exit;
  logic               w_cnt_inc;
  logic               w_cnt_dec;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_load_val;
  logic               w_tmr_run;
  logic               w_tmr_done;

  // A request pulse counts in the same cycle it arrives, so an idle gate
  // opens on the very next edge.
  assign w_entry_pend = r_entry_pend | entry_req;
  assign w_exit_pend  = r_exit_pend | exit_req;
  assign w_entry_ok   = (r_count < CAP_C);
  assign w_exit_ok    = (r_count != '0);
  assign w_deny_entry = w_entry_pend & ~w_entry_ok;
  assign w_deny_exit  = w_exit_pend & ~w_exit_ok;
  assign w_want_entry = w_entry_pend & w_entry_ok;
  assign w_want_exit  = w_exit_pend & w_exit_ok;

  gate_timer #(
    .WIDTH (TMR_W)
  ) u_gate_timer (
    .clk_sys    (clk),
    .rst_b      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_run      (w_tmr_run),
    .o_done     (w_tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, grant/deny decisions, occupancy updates and timer control.
  always_comb begin
    w_next_state   = r_state;
    w_clr_entry    = 1'b0;
    w_clr_exit     = 1'b0;
    w_deny         = 1'b0;
    w_grant_entry  = 1'b0;
    w_grant_exit   = 1'b0;
    w_cnt_inc      = 1'b0;
    w_cnt_dec      = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = OPEN_LOAD;
    w_tmr_run      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Rejections and a grant for the other side can share one cycle.
        w_clr_entry = w_deny_entry;
        w_clr_exit  = w_deny_exit;
        w_deny      = w_deny_entry | w_deny_exit;
        if (w_want_entry && w_want_exit) begin
          w_grant_entry = r_last_exit;
          w_grant_exit  = ~r_last_exit;
        end else begin
          w_grant_entry = w_want_entry;
          w_grant_exit  = w_want_exit;
        end
        if (w_grant_entry) begin
          w_next_state   = ST_OPEN_ENTRY;
          w_clr_entry    = 1'b1;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = OPEN_LOAD;
        end else if (w_grant_exit) begin
          w_next_state   = ST_OPEN_EXIT;
          w_clr_exit     = 1'b1;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = OPEN_LOAD;
        end
      end

      ST_OPEN_ENTRY: begin
        w_tmr_run = 1'b1;
        if (car_passed || w_tmr_done) begin
          w_cnt_inc      = car_passed & w_entry_ok;
          w_next_state   = ST_CLOSING;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = CLOSE_LOAD;
        end
      end

      ST_OPEN_EXIT: begin
        w_tmr_run = 1'b1;
        if (car_passed || w_tmr_done) begin
          w_cnt_dec      = car_passed & w_exit_ok;
          w_next_state   = ST_CLOSING;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = CLOSE_LOAD;
        end
      end

      ST_CLOSING: begin
        w_tmr_run = 1'b1;
        if (w_tmr_done) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Pending flags, occupancy, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry_pend  <= 1'b0;
      r_exit_pend   <= 1'b0;
      r_last_exit   <= 1'b0;
      r_count       <= '0;
      r_deny        <= 1'b0;
      r_gate_open   <= 1'b0;
      r_grant_entry <= 1'b0;
      r_grant_exit  <= 1'b0;
    end else begin
      r_entry_pend <= w_entry_pend & ~w_clr_entry;
      r_exit_pend  <= w_exit_pend & ~w_clr_exit;
      if (w_grant_exit) begin
        r_last_exit <= 1'b1;
      end else if (w_grant_entry) begin
        r_last_exit <= 1'b0;
      end
      if (w_cnt_inc) begin
        r_count <= r_count + 1'b1;
      end else if (w_cnt_dec) begin
        r_count <= r_count - 1'b1;
      end
      r_deny        <= w_deny;
      r_grant_entry <= (w_next_state == ST_OPEN_ENTRY);
      r_grant_exit  <= (w_next_state == ST_OPEN_EXIT);
      r_gate_open   <= (w_next_state == ST_OPEN_ENTRY) ||
                       (w_next_state == ST_OPEN_EXIT);
    end
  end

  assign gate_open   = r_gate_open;
  assign grant_entry = r_grant_entry;
  assign grant_exit  = r_grant_exit;
  assign deny        = r_deny;
  assign led_counter = r_count;
  assign full        = (r_count == CAP_C);

endmodule
